// File: rtl/gelu_du_pkg.sv
// Shared types for the GELU division unit: exponent and normalised-operand formats
// exchanged between the LOD normaliser and the reciprocal stage.
package gelu_du_pkg;
  localparam int DU_W   = 32;
  localparam int DU_Q   = 16;
  localparam int DU_F   = 16;
  localparam int LOD_PW = $clog2(DU_W);
  localparam int DU_EW  = LOD_PW + 2;

  typedef logic signed [DU_EW-1:0] du_exp_t;

  typedef struct packed {
    logic [DU_F-1:0] mant;
    du_exp_t         exp;
    logic            sticky;
    logic            zero;
  } du_norm_t;
endpackage

// File: rtl/lod_norm_shifter.sv
// Combinational W-bit left barrel shifter, one mux level per bit of the shift amount.
module lod_norm_shifter #(
  parameter int W  = 32,
  parameter int SW = $clog2(W)
) (
  input  logic [W-1:0]  data_i,
  input  logic [SW-1:0] amt_i,
  output logic [W-1:0]  data_o
);
  logic [SW:0][W-1:0] stg;

  assign stg[0] = data_i;

  for (genvar l = 0; l < SW; l++) begin : g_lvl
    assign stg[l+1] = amt_i[l] ? (stg[l] << (1 << l)) : stg[l];
  end

  assign data_o = stg[SW];
endmodule

// File: rtl/lod_normalizer.sv
// Left-normalises an operand using the LOD result into hidden-one mantissa, signed
// exponent and sticky bit; 2-stage valid/ready pipeline with a latched consistency error.
module lod_normalizer
  import gelu_du_pkg::*;
#(
  parameter int W = DU_W,
  parameter int Q = DU_Q,
  parameter int F = DU_F
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  output logic                        ready_in,
  input  logic [W-1:0]                data_in,
  input  logic [$clog2(W)-1:0]        lod_pos,
  input  logic                        found,
  output logic                        valid_out,
  input  logic                        ready_out,
  output logic [F-1:0]                mant_out,
  output logic [$clog2(W)+1:0]        exp_out,
  output logic                        sticky_out,
  output logic                        zero_out,
  output logic                        err_out
);
  localparam int PW = $clog2(W);
  localparam int EW = PW + 2;

  typedef struct packed {
    logic [F-1:0]          mant;
    logic signed [EW-1:0]  exp;
    logic                  sticky;
    logic                  zero;
  } norm_t;

  logic [2:1]   vld_q, vld_d;
  logic         s2_adv, s1_ld;

  logic [W-2:0] s1_sh_q, s1_sh_d;
  logic [PW-1:0] s1_pos_q, s1_pos_d;
  logic         s1_zero_q, s1_zero_d;
  logic         err_q, err_d;
  norm_t        s2_q, s2_d;

  logic [W-1:0] sh_c;
  logic [PW-1:0] amt_c;
  logic         above_c, chk_c;

  logic [F-1:0] mant_c;
  logic         sticky_c;

  // Stage k advances when empty or when its occupant leaves this same cycle.
  assign s2_adv   = !vld_q[2] | ready_out;
  assign ready_in = !vld_q[1] | s2_adv;
  assign s1_ld    = valid_in & ready_in;

  assign amt_c = PW'(W - 1) - lod_pos;

  lod_norm_shifter #(.W(W), .SW(PW)) u_shift (
    .data_i (data_in),
    .amt_i  (amt_c),
    .data_o (sh_c)
  );

  // The shifted MSB is data_in[lod_pos]; it must be 1 whenever the LOD claims found.
  always_comb begin
    above_c = 1'b0;
    for (int i = 0; i < W; i++)
      if (i > int'(lod_pos) && data_in[i]) above_c = 1'b1;
    chk_c = above_c | (found & ~sh_c[W-1]) | (~found & (|data_in));
  end

  always_comb begin
    vld_d     = vld_q;
    s1_sh_d   = s1_sh_q;
    s1_pos_d  = s1_pos_q;
    s1_zero_d = s1_zero_q;
    err_d     = err_q;
    if (ready_in) vld_d[1] = valid_in;
    if (s2_adv)   vld_d[2] = vld_q[1];
    if (s1_ld) begin
      s1_sh_d   = sh_c[W-2:0];
      s1_pos_d  = lod_pos;
      s1_zero_d = ~found;
      err_d     = err_q | chk_c;
    end
  end

  if (F <= W - 1) begin : g_mant_fit
    assign mant_c = s1_sh_q[W-2 -: F];
  end else begin : g_mant_pad
    assign mant_c = {s1_sh_q, {(F-W+1){1'b0}}};
  end

  if (F < W - 1) begin : g_sticky
    assign sticky_c = |s1_sh_q[W-2-F:0];
  end else begin : g_no_sticky
    assign sticky_c = 1'b0;
  end

  always_comb begin
    s2_d = s2_q;
    if (s2_adv && vld_q[1]) begin
      s2_d.zero   = s1_zero_q;
      s2_d.mant   = s1_zero_q ? '0 : mant_c;
      s2_d.sticky = s1_zero_q ? 1'b0 : sticky_c;
      s2_d.exp    = s1_zero_q ? '0 : ($signed({2'b00, s1_pos_q}) - $signed(EW'(Q)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      s1_sh_q   <= '0;
      s1_pos_q  <= '0;
      s1_zero_q <= 1'b0;
      err_q     <= 1'b0;
      s2_q      <= '0;
    end else begin
      vld_q     <= vld_d;
      s1_sh_q   <= s1_sh_d;
      s1_pos_q  <= s1_pos_d;
      s1_zero_q <= s1_zero_d;
      err_q     <= err_d;
      s2_q      <= s2_d;
    end
  end

  assign valid_out  = vld_q[2];
  assign mant_out   = s2_q.mant;
  assign exp_out    = s2_q.exp;
  assign sticky_out = s2_q.sticky;
  assign zero_out   = s2_q.zero;
  assign err_out    = err_q;
endmodule

// File: tb/tb_lod_normalizer.sv
// Directed bench for lod_normalizer at W=32, Q=16, F=16.
module tb_lod_normalizer;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, ready_in, found;
  logic [31:0] data_in;
  logic [4:0]  lod_pos;
  logic        valid_out, ready_out;
  logic [15:0] mant_out;
  logic [6:0]  exp_out;
  logic        sticky_out, zero_out, err_out;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] m;
    logic [6:0]  e;
    logic        s;
    logic        z;
  } res_t;

  res_t q[$];

  always #5 clk = ~clk;

  lod_normalizer #(.W(32), .Q(16), .F(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .data_in    (data_in),
    .lod_pos    (lod_pos),
    .found      (found),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .mant_out   (mant_out),
    .exp_out    (exp_out),
    .sticky_out (sticky_out),
    .zero_out   (zero_out),
    .err_out    (err_out)
  );

  // Inputs only change just after posedge, so a negedge sample predicts the next edge.
  always @(negedge clk)
    if (!rst && valid_out && ready_out)
      q.push_back('{m: mant_out, e: exp_out, s: sticky_out, z: zero_out});

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; ready_out = 1'b1;
    data_in = '0; lod_pos = '0; found = 1'b0;
    #3;
    total++;
    if ({valid_out, mant_out, exp_out, sticky_out, zero_out, err_out} !== 27'd0)
      $display("FAIL reset_outputs: got v=%b m=%h e=%h s=%b z=%b err=%b, want all 0",
               valid_out, mant_out, exp_out, sticky_out, zero_out, err_out);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if (ready_in !== 1'b1 || valid_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got ready_in=%b valid_out=%b, want 1 0", ready_in, valid_out);
    end
  endtask

  task automatic run_one(input string nm, input logic [31:0] d, input logic [4:0] p,
                         input logic f, input logic [15:0] em, input logic [6:0] ee,
                         input logic es, input logic ez);
    @(posedge clk); #1;
    valid_in = 1'b1; data_in = d; lod_pos = p; found = f;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0) begin
      bad++;
      $display("FAIL %s_early: valid_out=%b one cycle after transfer, want 0", nm, valid_out);
    end
    @(negedge clk);
    total++;
    if (valid_out !== 1'b1 || mant_out !== em || exp_out !== ee ||
        sticky_out !== es || zero_out !== ez) begin
      bad++;
      $display("FAIL %s: got v=%b m=%h e=%h s=%b z=%b, want v=1 m=%h e=%h s=%b z=%b",
               nm, valid_out, mant_out, exp_out, sticky_out, zero_out, em, ee, es, ez);
    end
  endtask

  task automatic test_arith();
    run_one("one_point_five", 32'h0001_8000, 5'd16, 1'b1, 16'h8000, 7'h00, 1'b0, 1'b0);
    run_one("msb_and_lsb",    32'h8000_0001, 5'd31, 1'b1, 16'h0000, 7'h0F, 1'b1, 1'b0);
    run_one("lsb_only",       32'h0000_0001, 5'd0,  1'b1, 16'h0000, 7'h70, 1'b0, 1'b0);
    run_one("pattern_abcd",   32'h0000_ABCD, 5'd15, 1'b1, 16'h579A, 7'h7F, 1'b0, 1'b0);
    run_one("ones_24",        32'h00FF_FFFF, 5'd23, 1'b1, 16'hFFFF, 7'h07, 1'b1, 1'b0);
  endtask

  task automatic test_zero();
    run_one("zero_operand", 32'h0, 5'd5, 1'b0, 16'h0000, 7'h00, 1'b0, 1'b1);
    total++;
    if (err_out !== 1'b0) begin
      bad++;
      $display("FAIL zero_err: err_out=%b, want 0", err_out);
    end
  endtask

  task automatic test_back_to_back();
    res_t prev;
    logic held = 1'b0;
    int   idx = 0;
    @(posedge clk); @(negedge clk);
    q.delete();
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      ready_out = !(c >= 3 && c <= 7);
      if (idx < 6) begin
        valid_in = 1'b1; data_in = 32'h3 << (7 + idx); lod_pos = 5'(8 + idx); found = 1'b1;
      end else valid_in = 1'b0;
      @(negedge clk);
      if (c == 3) begin
        total++;
        if (ready_in !== 1'b0) begin
          bad++;
          $display("FAIL bp_ready_in: ready_in=%b with both stages full, want 0", ready_in);
        end
      end
      if (valid_out && !ready_out) begin
        if (held) begin
          total++;
          if ({mant_out, exp_out, sticky_out, zero_out} !== prev) begin
            bad++;
            $display("FAIL bp_hold: cycle %0d got %h, want held %h", c,
                     {mant_out, exp_out, sticky_out, zero_out}, prev);
          end
        end
        held = 1'b1;
        prev = '{m: mant_out, e: exp_out, s: sticky_out, z: zero_out};
      end else held = 1'b0;
      if (valid_in && ready_in) idx++;
    end
    ready_out = 1'b1;
    total++;
    if (q.size() != 6) begin
      bad++;
      $display("FAIL bp_count: got %0d results, want 6", q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (q[i].e !== 7'(i - 8) || q[i].m !== 16'h8000 || q[i].s !== 1'b0) begin
          bad++;
          $display("FAIL bp_order[%0d]: got m=%h e=%h s=%b, want m=8000 e=%h s=0",
                   i, q[i].m, q[i].e, q[i].s, 7'(i - 8));
        end
      end
    end
  endtask

  task automatic test_err_and_flush();
    @(posedge clk); #1;
    valid_in = 1'b1; data_in = 32'h0000_0100; lod_pos = 5'd4; found = 1'b1;
    @(negedge clk);
    total++;
    if (err_out !== 1'b0) begin
      bad++;
      $display("FAIL err_before_load: err_out=%b, want 0", err_out);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
    total++;
    if (err_out !== 1'b1) begin
      bad++;
      $display("FAIL err_set: err_out=%b, want 1", err_out);
    end
    run_one("after_err", 32'h0001_8000, 5'd16, 1'b1, 16'h8000, 7'h00, 1'b0, 1'b0);
    total++;
    if (err_out !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: err_out=%b after good input, want 1", err_out);
    end
    // Two results in flight, held by backpressure, then an async reset.
    @(posedge clk); #1;
    ready_out = 1'b0;
    valid_in = 1'b1; data_in = 32'h0000_0001; lod_pos = 5'd0; found = 1'b1;
    @(posedge clk); #1;
    data_in = 32'h0000_0002; lod_pos = 5'd1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    #2 rst = 1'b1;
    q.delete();
    #1;
    total++;
    if (valid_out !== 1'b0 || err_out !== 1'b0) begin
      bad++;
      $display("FAIL flush_async: valid_out=%b err_out=%b during rst, want 0 0", valid_out, err_out);
    end
    @(negedge clk); rst = 1'b0; ready_out = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (q.size() != 0 || valid_out !== 1'b0) begin
      bad++;
      $display("FAIL flush_none: %0d results emitted after rst, valid_out=%b, want 0 0",
               q.size(), valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_zero();
    test_back_to_back();
    test_err_and_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
